// File: rtl/hwpe_ownership_scheduler_pkg.sv
// hwpe_ownership_scheduler_pkg: shared HWPE sizing and the scheduler FSM state type
package hwpe_ownership_scheduler_pkg;
  localparam int MAX_NUM_HWPES = 4;
  localparam int SEL_W = $clog2(MAX_NUM_HWPES);
  typedef enum logic [2:0] {IDLE, DRAIN, GATE_OFF, GATE_ON, OWNED} hwpe_sched_state_e;
endpackage

// File: rtl/hwpe_sched_rr_arb.sv
// hwpe_sched_rr_arb: N-input round-robin arbiter, pointer moves past the winner on accept
// ports: req_i requests, accept_i winner taken this cycle, valid_o any request, idx_o winner index
module hwpe_sched_rr_arb
  import hwpe_ownership_scheduler_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 accept_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int W = $clog2(N);
  logic [W-1:0] ptr_q;
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid_o && req_i[(int'(ptr_q) + i) % N]) begin
        valid_o = 1'b1;
        idx_o   = W'((int'(ptr_q) + i) % N);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else if (accept_i && valid_o) ptr_q <= (idx_o == W'(N - 1)) ? '0 : idx_o + 1'b1;
  end
endmodule

// File: rtl/hwpe_ownership_scheduler.sv
// hwpe_ownership_scheduler: grants exclusive ownership of one HWPE at a time to N_CORES requesters
// ports: req_i/req_hwpe_i/rel_i per-core request, index, release; gnt_o/err_o per-core grant, reject;
//        owner_valid_o/owner_o current owner; busy_i, cfg_* subsystem status; hwpe_en_o/hwpe_sel_o to subsystem
// HWPE_SCHED_IDLE_GATE_EN: drop hwpe_en_o after IDLE_CYCLES idle cycles with no owner
module hwpe_ownership_scheduler
  import hwpe_ownership_scheduler_pkg::*;
#(
  parameter int N_CORES     = 8,
  parameter int N_HWPES     = 1,
  parameter int GATE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int OUTST_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CORES-1:0]         req_i,
  input  logic [N_CORES*SEL_W-1:0]   req_hwpe_i,
  input  logic [N_CORES-1:0]         rel_i,
  output logic [N_CORES-1:0]         gnt_o,
  output logic [N_CORES-1:0]         err_o,
  output logic                       owner_valid_o,
  output logic [$clog2(N_CORES)-1:0] owner_o,
  input  logic                       busy_i,
  input  logic                       cfg_req_i,
  input  logic                       cfg_gnt_i,
  input  logic                       cfg_r_valid_i,
  output logic                       hwpe_en_o,
  output logic [SEL_W-1:0]           hwpe_sel_o
);
  localparam int IDX_W = $clog2(N_CORES);
  localparam int GW    = $clog2(GATE_CYCLES) + 1;
  localparam int IW    = $clog2(IDLE_CYCLES) + 1;
`ifdef HWPE_SCHED_IDLE_GATE_EN
  localparam bit IDLE_GATE = 1'b1;
`else
  localparam bit IDLE_GATE = 1'b0;
`endif
  hwpe_sched_state_e  state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d, win_idx;
  logic [SEL_W-1:0]   sel_q, sel_d, tgt_q, tgt_d, win_sel;
  logic               en_q, en_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [IW-1:0]      icnt_q;
  logic [OUTST_W-1:0] outst_q;
  logic [N_CORES-1:0] bad_req;
  logic               win_valid, accept, inc, dec, idle_cond, idle_off;
  always_comb begin
    bad_req = '0;
    for (int c = 0; c < N_CORES; c++)
      bad_req[c] = req_i[c] && (int'(req_hwpe_i[c*SEL_W +: SEL_W]) >= N_HWPES);
  end
  hwpe_sched_rr_arb #(.N(N_CORES)) i_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i & ~bad_req),
    .accept_i (accept),
    .valid_o  (win_valid),
    .idx_o    (win_idx)
  );
  assign win_sel = req_hwpe_i[win_idx*SEL_W +: SEL_W];
  assign accept  = (state_q == IDLE) && win_valid;
  assign inc     = cfg_req_i && cfg_gnt_i;
  assign dec     = cfg_r_valid_i;
  // idle gating only counts while nobody owns or wants the HWPE and nothing is in flight
  assign idle_cond = IDLE_GATE && (state_q == IDLE) && (req_i == '0) && !busy_i && (outst_q == '0);
  assign idle_off  = idle_cond && (icnt_q == IW'(IDLE_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tgt_d   = tgt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          owner_d = win_idx;
          tgt_d   = win_sel;
          state_d = (en_q && win_sel == sel_q) ? OWNED : DRAIN;
        end else if (idle_off) en_d = 1'b0;
      end
      DRAIN: begin
        if (!busy_i && outst_q == '0) begin
          state_d = GATE_OFF;
          en_d    = 1'b0;
          sel_d   = tgt_q;
          gcnt_d  = '0;
        end
      end
      GATE_OFF: begin
        if (gcnt_q == GW'(GATE_CYCLES - 1)) begin
          state_d = GATE_ON;
          en_d    = 1'b1;
        end else gcnt_d = gcnt_q + 1'b1;
      end
      GATE_ON: state_d = OWNED;
      OWNED:   state_d = rel_i[owner_q] ? IDLE : OWNED;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      tgt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gcnt_q  <= gcnt_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) icnt_q <= '0;
    else icnt_q <= (idle_cond && !idle_off) ? icnt_q + 1'b1 : '0;
  end
  // saturating: over/underflow is flagged by the assertions below rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outst_q <= '0;
    else if (inc && !dec && !(&outst_q)) outst_q <= outst_q + 1'b1;
    else if (dec && !inc && outst_q != '0) outst_q <= outst_q - 1'b1;
  end
  a_outst_ovf: assert property (@(posedge clk) disable iff (!rst_n) !(inc && !dec && (&outst_q)));
  a_outst_udf: assert property (@(posedge clk) disable iff (!rst_n) !(dec && !inc && outst_q == '0));
  assign gnt_o         = (state_q == OWNED) ? (N_CORES'(1) << owner_q) : '0;
  assign err_o         = (state_q == IDLE) ? bad_req : '0;
  assign owner_valid_o = (state_q == OWNED);
  assign owner_o       = owner_q;
  assign hwpe_en_o     = en_q;
  assign hwpe_sel_o    = sel_q;
endmodule

// File: tb/tb_hwpe_ownership_scheduler.sv
// tb_hwpe_ownership_scheduler: directed scoreboard bench for the HWPE ownership scheduler
module tb_hwpe_ownership_scheduler;
  import hwpe_ownership_scheduler_pkg::*;
  typedef struct {
    logic [7:0] gnt;
    logic [7:0] err;
    logic       en;
    logic [1:0] sel;
    int         cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req, rel, gnt, err;
  logic [15:0] req_hwpe;
  logic        owner_valid, busy, cfg_req, cfg_gnt, cfg_r_valid, en;
  logic [2:0]  owner;
  logic [1:0]  sel;
  logic [7:0]  prev_gnt = '0;
  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          c0, r, d;
  hwpe_ownership_scheduler #(
    .N_CORES(8), .N_HWPES(2), .GATE_CYCLES(2), .IDLE_CYCLES(16), .OUTST_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_hwpe_i(req_hwpe), .rel_i(rel),
    .gnt_o(gnt), .err_o(err), .owner_valid_o(owner_valid), .owner_o(owner),
    .busy_i(busy), .cfg_req_i(cfg_req), .cfg_gnt_i(cfg_gnt), .cfg_r_valid_i(cfg_r_valid),
    .hwpe_en_o(en), .hwpe_sel_o(sel)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask
  task automatic wait_gnt(input int core, input int budget);
    int n = 0;
    while (!gnt[core] && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("gnt_wait_core%0d", core), 32'(gnt[core]), 1);
  endtask
  task automatic push(input logic [7:0] g, input logic [7:0] er, input logic en_x,
                      input logic [1:0] s, input int c);
    q.push_back('{gnt: g, err: er, en: en_x, sel: s, cyc: c});
  endtask
  task automatic set_req(input int core, input logic [1:0] idx);
    req[core] = 1'b1;
    req_hwpe[core*2 +: 2] = idx;
  endtask
  always @(negedge clk) begin
    if (rst_n && ((gnt != 0 && gnt != prev_gnt) || err != 0)) begin
      if (q.size() == 0) chk("unexpected_event", {16'h0, gnt, err}, 0);
      else begin
        e = q.pop_front();
        chk("evt_gnt", 32'(gnt), 32'(e.gnt));
        chk("evt_err", 32'(err), 32'(e.err));
        chk("evt_en", 32'(en), 32'(e.en));
        chk("evt_sel", 32'(sel), 32'(e.sel));
        chk("evt_cycle", cyc, e.cyc);
      end
    end
    prev_gnt = gnt;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; req = '0; rel = '0; req_hwpe = '0;
    busy = 1'b0; cfg_req = 1'b0; cfg_gnt = 1'b0; cfg_r_valid = 1'b0;
    step(2);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_owner_valid", 32'(owner_valid), 0);
    chk("rst_owner", 32'(owner), 0);
    rst_n = 1'b1;
    step();
    c0 = cyc;
    set_req(0, 2'd0);
    push(8'h01, 8'h00, 1'b1, 2'd0, c0 + 5);
    wait_until(c0 + 2);
    chk("t1_en_c2", 32'(en), 0);
    wait_until(c0 + 3);
    chk("t1_en_c3", 32'(en), 0);
    chk("t1_sel_c3", 32'(sel), 0);
    wait_until(c0 + 4);
    chk("t1_en_c4", 32'(en), 1);
    chk("t1_gnt_c4", 32'(gnt), 0);
    wait_until(c0 + 5);
    chk("t1_owner_valid", 32'(owner_valid), 1);
    req[0] = 1'b0;
    step(2);
    chk("t1_hold_without_req", 32'(gnt), 32'h01);
    rel[0] = 1'b1;
    step();
    rel[0] = 1'b0;
    chk("t2_gnt_drop", 32'(gnt), 0);
    c0 = cyc;
    set_req(3, 2'd0);
    push(8'h08, 8'h00, 1'b1, 2'd0, c0 + 1);
    wait_gnt(3, 10);
    req[3] = 1'b0;
    chk("t2_owner", 32'(owner), 3);
    c0 = cyc;
    rel[3] = 1'b1;
    set_req(1, 2'd1);
    set_req(2, 2'd0);
    push(8'h02, 8'h00, 1'b1, 2'd1, c0 + 6);
    step();
    rel[3] = 1'b0;
    wait_gnt(1, 20);
    req[1] = 1'b0;
    chk("t3_owner", 32'(owner), 1);
    step(2);
    c0 = cyc;
    rel[1] = 1'b1;
    push(8'h04, 8'h00, 1'b1, 2'd0, c0 + 6);
    step();
    rel[1] = 1'b0;
    wait_gnt(2, 20);
    req[2] = 1'b0;
    rel[5] = 1'b1;
    step();
    rel[5] = 1'b0;
    step();
    chk("t3_nonowner_rel", 32'(gnt), 32'h04);
    busy = 1'b1; cfg_req = 1'b1; cfg_gnt = 1'b1;
    step(2);
    cfg_req = 1'b0; cfg_gnt = 1'b0;
    rel[2] = 1'b1;
    set_req(6, 2'd1);
    step();
    rel[2] = 1'b0;
    repeat (4) begin
      step();
      chk("t4_drain_sel", 32'(sel), 0);
      chk("t4_drain_gnt", 32'(gnt), 0);
    end
    busy = 1'b0;
    step();
    chk("t4_outst2_sel", 32'(sel), 0);
    cfg_r_valid = 1'b1;
    step();
    chk("t4_outst1_sel", 32'(sel), 0);
    r = cyc;
    push(8'h40, 8'h00, 1'b1, 2'd1, r + 5);
    step();
    cfg_r_valid = 1'b0;
    wait_gnt(6, 20);
    req[6] = 1'b0;
    rel[6] = 1'b1;
    step();
    rel[6] = 1'b0;
    step();
    c0 = cyc;
    set_req(5, 2'd3);
    push(8'h00, 8'h20, 1'b1, 2'd1, c0);
    step();
    req[5] = 1'b0;
    d = cyc;
    step(3);
    chk("t5_no_gnt", 32'(gnt), 0);
    chk("t5_en_kept", 32'(en), 1);
    chk("t5_sel_kept", 32'(sel), 1);
`ifdef HWPE_SCHED_IDLE_GATE_EN
    wait_until(d + 15);
    chk("t6_en_before_gate", 32'(en), 1);
    wait_until(d + 16);
    chk("t6_en_gated", 32'(en), 0);
`else
    wait_until(d + 20);
    chk("t6_en_stays", 32'(en), 1);
`endif
    c0 = cyc;
    set_req(0, 2'd0);
    wait_until(c0 + 2);
    chk("t7_gate_off_en", 32'(en), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_gnt", 32'(gnt), 0);
    chk("t7_rst_en", 32'(en), 0);
    chk("t7_rst_sel", 32'(sel), 0);
    chk("t7_rst_owner_valid", 32'(owner_valid), 0);
    chk("t7_rst_owner", 32'(owner), 0);
    chk("t7_rst_err", 32'(err), 0);
    req[0] = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
